// File: rtl/regfile_scoreboard_if.sv
// Decode/execute/write-back bundle for regfile_scoreboard: read ports, issue, kill,
// write-back and sticky error flags. master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr_d;
    logic [AW-1:0]   rs2_addr_d;
    logic [XLEN-1:0] rs1_data_d;
    logic [XLEN-1:0] rs2_data_d;
    logic            rs1_busy_d;
    logic            rs2_busy_d;
    logic            issue_valid_d;
    logic [AW-1:0]   issue_rd_d;
    logic            issue_regwr_d;
    logic            kill_valid_e;
    logic [AW-1:0]   kill_rd_e;
    logic            kill_regwr_e;
    logic            RegWriteW;
    logic [AW-1:0]   RDW;
    logic [XLEN-1:0] ResultW;
    logic            err_overflow;
    logic            err_underflow;

    modport master (
        output rs1_addr_d, rs2_addr_d,
        output issue_valid_d, issue_rd_d, issue_regwr_d,
        output kill_valid_e, kill_rd_e, kill_regwr_e,
        output RegWriteW, RDW, ResultW,
        input  rs1_data_d, rs2_data_d, rs1_busy_d, rs2_busy_d,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  rs1_addr_d, rs2_addr_d,
        input  issue_valid_d, issue_rd_d, issue_regwr_d,
        input  kill_valid_e, kill_rd_e, kill_regwr_e,
        input  RegWriteW, RDW, ResultW,
        output rs1_data_d, rs2_data_d, rs1_busy_d, rs2_busy_d,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters for the hazard unit.
// Optional macro REGFILE_BYPASS_EN: write-first read path and same-cycle retire clears busy.
module regfile_scoreboard_entry #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CNTW = 3,
    parameter int IDX  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            inc_en,
    input  logic [AW-1:0]   inc_rd,
    input  logic            kill_en,
    input  logic [AW-1:0]   kill_rd,
    output logic [XLEN-1:0] data,
    output logic [CNTW-1:0] cnt,
    output logic            ovf,
    output logic            unf
);
    localparam int            NW = CNTW + 2;
    localparam logic [AW-1:0] ME = AW'(IDX);

    logic          hit_wb, hit_inc, hit_kill;
    logic [NW-1:0] net;

    assign hit_wb   = wb_en   && (wb_rd   == ME);
    assign hit_inc  = inc_en  && (inc_rd  == ME);
    assign hit_kill = kill_en && (kill_rd == ME);

    // Two extra bits hold the net result: range is -2 .. 2^CNTW, top bit is the sign.
    assign net = {2'b00, cnt} + NW'(hit_inc) - NW'(hit_wb) - NW'(hit_kill);
    assign unf = net[NW-1];
    assign ovf = !net[NW-1] && net[CNTW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else begin
            if (hit_wb) data <= wb_data;
            if (unf)      cnt <= '0;
            else if (ovf) cnt <= '1;
            else          cnt <= net[CNTW-1:0];
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CNTW = 3
) (
    input logic                clk,
    input logic                rst_n,
    regfile_scoreboard_if.slave bus
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NREG-1:0]           ovf, unf;
    logic                      err_ovf_q, err_unf_q;
    logic                      wb_live;
    logic [1:0][AW-1:0]        raddr;
    logic [1:0][XLEN-1:0]      rdata;
    logic [1:0]                rbusy;

    // x0 has no storage and no counter.
    assign regs[0] = '0;
    assign cnt[0]  = '0;
    assign ovf[0]  = 1'b0;
    assign unf[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        regfile_scoreboard_entry #(
            .XLEN(XLEN), .AW(AW), .CNTW(CNTW), .IDX(r)
        ) u_ent (
            .clk     (clk),
            .rst_n   (rst_n),
            .wb_en   (bus.RegWriteW),
            .wb_rd   (bus.RDW),
            .wb_data (bus.ResultW),
            .inc_en  (bus.issue_valid_d & bus.issue_regwr_d),
            .inc_rd  (bus.issue_rd_d),
            .kill_en (bus.kill_valid_e & bus.kill_regwr_e),
            .kill_rd (bus.kill_rd_e),
            .data    (regs[r]),
            .cnt     (cnt[r]),
            .ovf     (ovf[r]),
            .unf     (unf[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | (|ovf);
            err_unf_q <= err_unf_q | (|unf);
        end
    end

    assign wb_live = bus.RegWriteW && (bus.RDW != '0);
    assign raddr   = {bus.rs2_addr_d, bus.rs1_addr_d};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = (cnt[raddr[p]] != '0);
`ifdef REGFILE_BYPASS_EN
            // A retire landing this cycle is forwarded; if it is the last pending write, busy drops.
            if (wb_live && (bus.RDW == raddr[p])) begin
                rdata[p] = bus.ResultW;
                if (cnt[raddr[p]] == CNTW'(1)) rbusy[p] = 1'b0;
            end
`endif
        end
    end

    assign bus.rs1_data_d    = rdata[0];
    assign bus.rs2_data_d    = rdata[1];
    assign bus.rs1_busy_d    = rbusy[0];
    assign bus.rs2_busy_d    = rbusy[1];
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: vector table, directed corner sequences and a randomized
// run checked against an array-based reference model.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CMAX = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .AW(5)) ifc ();
    regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .CNTW(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    int nchk = 0;
    int nerr = 0;

    logic [31:0] mregs [32];
    int          mcnt  [32];
    bit          movf, munf;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        iss;
        logic [4:0]  ird;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] e1d;
        logic        e1b;
        logic [31:0] e2d;
        logic        e2b;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mregs[r] = '0;
            mcnt[r]  = 0;
        end
        movf = 1'b0;
        munf = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return '0;
        if (BYP && ifc.RegWriteW && ifc.RDW == a) return ifc.ResultW;
        return mregs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0 || mcnt[a] == 0) return 1'b0;
        if (BYP && ifc.RegWriteW && ifc.RDW == a && mcnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clk();
        int n;
        for (int r = 1; r < 32; r++) begin
            n = mcnt[r];
            if (ifc.issue_valid_d && ifc.issue_regwr_d && ifc.issue_rd_d == r) n = n + 1;
            if (ifc.RegWriteW && ifc.RDW == r) n = n - 1;
            if (ifc.kill_valid_e && ifc.kill_regwr_e && ifc.kill_rd_e == r) n = n - 1;
            if (n > CMAX) begin mcnt[r] = CMAX; movf = 1'b1; end
            else if (n < 0) begin mcnt[r] = 0; munf = 1'b1; end
            else mcnt[r] = n;
        end
        if (ifc.RegWriteW && ifc.RDW != 0) mregs[ifc.RDW] = ifc.ResultW;
    endtask

    task automatic idle();
        ifc.issue_valid_d = 0; ifc.issue_rd_d = 0; ifc.issue_regwr_d = 0;
        ifc.kill_valid_e  = 0; ifc.kill_rd_e  = 0; ifc.kill_regwr_e  = 0;
        ifc.RegWriteW     = 0; ifc.RDW        = 0; ifc.ResultW       = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        ifc.issue_valid_d = 1; ifc.issue_regwr_d = 1; ifc.issue_rd_d = rd;
    endtask

    task automatic retire(input logic [4:0] rd, input logic [31:0] d);
        ifc.RegWriteW = 1; ifc.RDW = rd; ifc.ResultW = d;
    endtask

    // Called just after a falling edge with inputs settled: check, clock, advance model.
    task automatic step();
        #2;
        chk("m_rs1_data", ifc.rs1_data_d, exp_data(ifc.rs1_addr_d));
        chk("m_rs1_busy", 32'(ifc.rs1_busy_d), 32'(exp_busy(ifc.rs1_addr_d)));
        chk("m_rs2_data", ifc.rs2_data_d, exp_data(ifc.rs2_addr_d));
        chk("m_rs2_busy", 32'(ifc.rs2_busy_d), 32'(exp_busy(ifc.rs2_addr_d)));
        chk("m_err_ovf", 32'(ifc.err_overflow), 32'(movf));
        chk("m_err_unf", 32'(ifc.err_underflow), 32'(munf));
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    initial begin
        ifc.rs1_addr_d = 0;
        ifc.rs2_addr_d = 0;
        idle();
        model_reset();

        tbl[0] = '{5'd0, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,
                   32'h0, 1'b0, 32'h0, 1'b0};
        tbl[1] = '{5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 32'hFFFF_FFFF,
                   32'h0, 1'b1, 32'h0, 1'b0};
        tbl[2] = '{5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA,
                   BYP ? 32'hA : 32'h0, 1'b1, 32'h0, 1'b0};
        tbl[3] = '{5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hB,
                   BYP ? 32'hB : 32'hA, !BYP, 32'h0, 1'b0};
        tbl[4] = '{5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                   32'hB, 1'b0, 32'hB, 1'b0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // x0 write, two issues then two retires to x7
        for (int i = 0; i < 5; i++) begin
            idle();
            ifc.rs1_addr_d = tbl[i].rs1;
            ifc.rs2_addr_d = tbl[i].rs2;
            if (tbl[i].iss) issue(tbl[i].ird);
            if (tbl[i].we)  retire(tbl[i].wrd, tbl[i].wd);
            #1;
            chk($sformatf("t%0d_rs1_data", i), ifc.rs1_data_d, tbl[i].e1d);
            chk($sformatf("t%0d_rs1_busy", i), 32'(ifc.rs1_busy_d), 32'(tbl[i].e1b));
            chk($sformatf("t%0d_rs2_data", i), ifc.rs2_data_d, tbl[i].e2d);
            chk($sformatf("t%0d_rs2_busy", i), 32'(ifc.rs2_busy_d), 32'(tbl[i].e2b));
            step();
        end

        // issue + kill + retire on x3 in one cycle with one already pending
        idle(); issue(3); step();
        idle(); issue(3); ifc.kill_valid_e = 1; ifc.kill_regwr_e = 1; ifc.kill_rd_e = 3;
        retire(3, 32'h33); step();
        idle(); ifc.rs1_addr_d = 3; #1;
        chk("t4_busy", 32'(ifc.rs1_busy_d), 32'h0);
        chk("t4_data", ifc.rs1_data_d, 32'h33);
        chk("t4_err", {30'h0, ifc.err_overflow, ifc.err_underflow}, 32'h0);
        step();

        // same-cycle retire seen on read port 2
        idle(); issue(9); step();
        idle(); retire(9, 32'hDEAD_BEEF); ifc.rs2_addr_d = 9; #1;
        chk("t5_same_data", ifc.rs2_data_d, BYP ? 32'hDEAD_BEEF : 32'h0);
        chk("t5_same_busy", 32'(ifc.rs2_busy_d), BYP ? 32'h0 : 32'h1);
        step();
        idle(); #1;
        chk("t5_next_data", ifc.rs2_data_d, 32'hDEAD_BEEF);
        chk("t5_next_busy", 32'(ifc.rs2_busy_d), 32'h0);
        step();

        // counter saturation and underflow
        ifc.rs1_addr_d = 4;
        for (int i = 0; i < 7; i++) begin idle(); issue(4); step(); end
        idle(); #1;
        chk("t6_busy7", 32'(ifc.rs1_busy_d), 32'h1);
        chk("t6_ovf_before", 32'(ifc.err_overflow), 32'h0);
        issue(4); step();
        idle(); #1;
        chk("t6_ovf", 32'(ifc.err_overflow), 32'h1);
        retire(2, 32'h22); step();
        idle(); ifc.rs1_addr_d = 2; #1;
        chk("t6_unf", 32'(ifc.err_underflow), 32'h1);
        chk("t6_unf_busy", 32'(ifc.rs1_busy_d), 32'h0);
        chk("t6_unf_data", ifc.rs1_data_d, 32'h22);
        step();

        // asynchronous reset in the middle of traffic
        ifc.rs1_addr_d = 5;
        for (int i = 0; i < 3; i++) begin idle(); issue(5); step(); end
        idle(); retire(5, 32'h1234); step();
        idle(); #1;
        chk("t1_pre_data", ifc.rs1_data_d, 32'h1234);
        chk("t1_pre_busy", 32'(ifc.rs1_busy_d), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_data", ifc.rs1_data_d, 32'h0);
        chk("t1_busy", 32'(ifc.rs1_busy_d), 32'h0);
        chk("t1_err", {30'h0, ifc.err_overflow, ifc.err_underflow}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic; retires mostly target registers with writes in flight
        for (int i = 0; i < 600; i++) begin
            logic [4:0] w;
            idle();
            ifc.rs1_addr_d    = 5'($urandom_range(0, 7));
            ifc.rs2_addr_d    = 5'($urandom_range(0, 7));
            ifc.issue_valid_d = 1'($urandom_range(0, 1));
            ifc.issue_regwr_d = ($urandom_range(0, 3) != 0);
            ifc.issue_rd_d    = 5'($urandom_range(0, 7));
            ifc.kill_valid_e  = ($urandom_range(0, 5) == 0);
            ifc.kill_regwr_e  = 1'($urandom_range(0, 1));
            ifc.kill_rd_e     = 5'($urandom_range(0, 7));
            w = 5'($urandom_range(0, 7));
            if (mcnt[w] > 0 || $urandom_range(0, 15) == 0) retire(w, $urandom);
            if (i == 300) begin
                rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
